// File: rtl/ber_run_controller.sv
// ber_run_controller
// Run sequencer for the parallel BER core array. Each run:
//   holds the cores in reset, streams N_PROB Markov probability words into
//   them, releases reset, waits SETTLE_CYC, enables them until a bit/error
//   target (or abort/watchdog) fires, drains for DRAIN_CYC cycles and then
//   snapshots the summed counters.
//
// Optional feature: define BER_RUN_TIMEOUT_EN to add a 64-bit RUN-cycle
// watchdog (parameter MAX_RUN_CYC). When it fires, the run stops with the
// same cause code as an abort. Without the macro there is no watchdog logic.
//
// Ports
//   clk, rstn                     clock, async active-low reset
//   start                         1-cycle strobe, honoured in IDLE/DONE only
//   abort                         level, forces DRAIN from LOAD/SETTLE/RUN
//   target_bits, target_errors    stop thresholds (0 = no limit)
//   prob_valid/prob_data/prob_ready  host probability word stream
//   core_rstn, core_en            reset / enable to the core array
//   probability_in/probability_idx   word + table index to cores' loader
//   total_bits, total_bit_errors_post  summed counters from the cores
//   snap_bits, snap_errors        counters captured on entering DONE
//   busy, done, stop_cause        status (cause: 01 bits, 10 errors, 11 abort/timeout)
module ber_run_controller #(
  parameter int unsigned N_PROB     = 64,
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned DRAIN_CYC  = 65536
`ifdef BER_RUN_TIMEOUT_EN
  , parameter logic [63:0] MAX_RUN_CYC = 64'd1 << 40
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] target_bits,
  input  logic [63:0] target_errors,
  input  logic        prob_valid,
  input  logic [63:0] prob_data,
  output logic        prob_ready,
  output logic        core_rstn,
  output logic        core_en,
  output logic [63:0] probability_in,
  output logic [31:0] probability_idx,
  input  logic [63:0] total_bits,
  input  logic [63:0] total_bit_errors_post,
  output logic [63:0] snap_bits,
  output logic [63:0] snap_errors,
  output logic        busy,
  output logic        done,
  output logic [1:0]  stop_cause
);

  // One shared phase counter covers RESET, SETTLE and DRAIN; size it for the longest.
  localparam int unsigned CNT_MAX_A = (RST_CYCLES > SETTLE_CYC) ? RST_CYCLES : SETTLE_CYC;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > DRAIN_CYC) ? CNT_MAX_A : DRAIN_CYC;
  localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_BITS  = 2'b01;
  localparam logic [1:0] CAUSE_ERRS  = 2'b10;
  localparam logic [1:0] CAUSE_ABORT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  logic          rst_meta_q;
  logic          rst_sync_q;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   load_cnt_q;
  logic          prob_ready_q;
  logic          core_rstn_q;
  logic          core_en_q;
  logic [63:0]   probability_in_q;
  logic [31:0]   probability_idx_q;
  logic [63:0]   snap_bits_q;
  logic [63:0]   snap_errors_q;
  logic          busy_q;
  logic          done_q;
  logic [1:0]    stop_cause_q;

  logic          bits_hit_s;
  logic          errs_hit_s;
  logic          timeout_s;
  logic          stop_s;
  logic [1:0]    cause_s;

  // Reset synchronizer: assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

`ifdef BER_RUN_TIMEOUT_EN
  logic [63:0] run_cnt_q;

  // Watchdog fires in the MAX_RUN_CYC-th RUN cycle so core_en is high exactly that long.
  assign timeout_s = (run_cnt_q >= (MAX_RUN_CYC - 64'd1));

  // RUN-cycle counter: cleared outside RUN, saturates once the watchdog has fired.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      run_cnt_q <= 64'd0;
    end else if (state_q != ST_RUN) begin
      run_cnt_q <= 64'd0;
    end else if (!timeout_s) begin
      run_cnt_q <= run_cnt_q + 64'd1;
    end else begin
      run_cnt_q <= run_cnt_q;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Stop decode from this cycle's inputs; abort/timeout outrank errors, errors outrank bits.
  always_comb begin
    bits_hit_s = (target_bits != 64'd0) && (total_bits >= target_bits);
    errs_hit_s = (target_errors != 64'd0) && (total_bit_errors_post >= target_errors);
    stop_s     = abort | timeout_s | errs_hit_s | bits_hit_s;
    if (abort || timeout_s) begin
      cause_s = CAUSE_ABORT;
    end else if (errs_hit_s) begin
      cause_s = CAUSE_ERRS;
    end else if (bits_hit_s) begin
      cause_s = CAUSE_BITS;
    end else begin
      cause_s = CAUSE_NONE;
    end
  end

  // Run sequencer with all outputs registered on the transitions that change them.
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      load_cnt_q        <= 32'd0;
      prob_ready_q      <= 1'b0;
      core_rstn_q       <= 1'b0;
      core_en_q         <= 1'b0;
      probability_in_q  <= 64'd0;
      probability_idx_q <= 32'd0;
      snap_bits_q       <= 64'd0;
      snap_errors_q     <= 64'd0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      stop_cause_q      <= CAUSE_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            core_rstn_q  <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            stop_cause_q <= CAUSE_NONE;
          end
        end
        ST_RESET: begin
          if (cnt_q == CW'(RST_CYCLES - 1)) begin
            state_q      <= ST_LOAD;
            cnt_q        <= '0;
            load_cnt_q   <= 32'd0;
            prob_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_LOAD: begin
          // abort beats a simultaneous handshake so no word lands after it
          if (abort) begin
            state_q      <= ST_DRAIN;
            cnt_q        <= '0;
            prob_ready_q <= 1'b0;
            core_rstn_q  <= 1'b1;
            stop_cause_q <= CAUSE_ABORT;
          end else if (prob_valid && prob_ready_q) begin
            probability_in_q  <= prob_data;
            probability_idx_q <= load_cnt_q;
            load_cnt_q        <= load_cnt_q + 32'd1;
            if (load_cnt_q == 32'(N_PROB - 1)) begin
              state_q      <= ST_SETTLE;
              cnt_q        <= '0;
              prob_ready_q <= 1'b0;
              core_rstn_q  <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state_q      <= ST_DRAIN;
            cnt_q        <= '0;
            stop_cause_q <= CAUSE_ABORT;
          end else if (cnt_q == CW'(SETTLE_CYC - 1)) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            core_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          if (stop_s) begin
            state_q      <= ST_DRAIN;
            cnt_q        <= '0;
            core_en_q    <= 1'b0;
            stop_cause_q <= cause_s;
          end
        end
        ST_DRAIN: begin
          // snapshot taken on the DONE-entry edge, after the core pipeline has emptied
          if (cnt_q == CW'(DRAIN_CYC - 1)) begin
            state_q       <= ST_DONE;
            cnt_q         <= '0;
            snap_bits_q   <= total_bits;
            snap_errors_q <= total_bit_errors_post;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          cnt_q        <= '0;
          prob_ready_q <= 1'b0;
          core_rstn_q  <= 1'b0;
          core_en_q    <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          stop_cause_q <= CAUSE_NONE;
        end
      endcase
    end
  end

  assign prob_ready      = prob_ready_q;
  assign core_rstn       = core_rstn_q;
  assign core_en         = core_en_q;
  assign probability_in  = probability_in_q;
  assign probability_idx = probability_idx_q;
  assign snap_bits       = snap_bits_q;
  assign snap_errors     = snap_errors_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign stop_cause      = stop_cause_q;

endmodule

// File: tb/tb_ber_run_controller.sv
// Self-checking bench for ber_run_controller with a small configuration
// (N_PROB=4, RST_CYCLES=3, SETTLE_CYC=2, DRAIN_CYC=5, MAX_RUN_CYC=100).
module tb_ber_run_controller;

  localparam int N_PROB = 4;
  localparam int DRAIN  = 5;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [63:0] target_bits = 64'd0;
  logic [63:0] target_errors = 64'd0;
  logic        prob_valid = 1'b0;
  logic [63:0] prob_data = 64'd0;
  logic        prob_ready;
  logic        core_rstn;
  logic        core_en;
  logic [63:0] probability_in;
  logic [31:0] probability_idx;
  logic [63:0] total_bits = 64'd0;
  logic [63:0] total_bit_errors_post = 64'd0;
  logic [63:0] snap_bits;
  logic [63:0] snap_errors;
  logic        busy;
  logic        done;
  logic [1:0]  stop_cause;

  int checks = 0;
  int errors = 0;

  ber_run_controller #(
    .N_PROB(N_PROB), .RST_CYCLES(3), .SETTLE_CYC(2), .DRAIN_CYC(DRAIN)
`ifdef BER_RUN_TIMEOUT_EN
    , .MAX_RUN_CYC(64'd100)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .target_bits(target_bits), .target_errors(target_errors),
    .prob_valid(prob_valid), .prob_data(prob_data), .prob_ready(prob_ready),
    .core_rstn(core_rstn), .core_en(core_en),
    .probability_in(probability_in), .probability_idx(probability_idx),
    .total_bits(total_bits), .total_bit_errors_post(total_bit_errors_post),
    .snap_bits(snap_bits), .snap_errors(snap_errors),
    .busy(busy), .done(done), .stop_cause(stop_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        crstn;
    logic        en;
    logic        busy;
    logic        done;
    logic [1:0]  sc;
    logic [63:0] pin;
    logic [31:0] idx;
  } exp_t;

  typedef struct {
    logic        start;
    logic        pv;
    logic [63:0] pdata;
    exp_t        e;
  } vec_t;

  vec_t vecs[10];
  exp_t sb_q[$];

  function automatic vec_t mkv(input logic st, input logic pv, input logic [63:0] pd,
                               input logic rdy, input logic crs, input logic en,
                               input logic bsy, input logic dn, input logic [1:0] sc,
                               input logic [63:0] pin, input logic [31:0] idx);
    vec_t v;
    v.start = st; v.pv = pv; v.pdata = pd;
    v.e.ready = rdy; v.e.crstn = crs; v.e.en = en; v.e.busy = bsy;
    v.e.done = dn; v.e.sc = sc; v.e.pin = pin; v.e.idx = idx;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && !done; k++) tick();
    chk("wait_done", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_ready(input int budget);
    for (int k = 0; k < budget && !prob_ready; k++) tick();
    chk("wait_ready", {63'd0, prob_ready}, 64'd1);
  endtask

  // start a run with the host always valid and wait for the first RUN cycle
  task automatic start_and_run();
    start = 1'b1; prob_valid = 1'b1; prob_data = 64'h55;
    tick();
    start = 1'b0;
    chk("restart_sc_clear", {62'd0, stop_cause}, 64'd0);
    chk("restart_done_clear", {63'd0, done}, 64'd0);
    for (int k = 0; k < 40 && !core_en; k++) tick();
    prob_valid = 1'b0;
    chk("reach_run", {63'd0, core_en}, 64'd1);
  endtask

  initial begin
    exp_t e;
    int   drop_i;
    int   acc;
    int   en_cnt;
    logic fire;

    vecs[0] = mkv(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 32'd0);
    vecs[1] = mkv(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 32'd0);
    vecs[2] = mkv(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 32'd0);
    vecs[3] = mkv(1'b0, 1'b1, 64'hA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 32'd0);
    vecs[4] = mkv(1'b0, 1'b1, 64'hA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'hA, 32'd0);
    vecs[5] = mkv(1'b0, 1'b1, 64'hB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'hB, 32'd1);
    vecs[6] = mkv(1'b0, 1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'hC, 32'd2);
    vecs[7] = mkv(1'b0, 1'b1, 64'hD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 64'hD, 32'd3);
    vecs[8] = mkv(1'b0, 1'b1, 64'hE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 64'hD, 32'd3);
    vecs[9] = mkv(1'b0, 1'b1, 64'hE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 64'hD, 32'd3);

    // reset state
    repeat (3) tick();
    rstn = 1'b1;
    repeat (4) tick();
    chk("rst_ready", {63'd0, prob_ready}, 64'd0);
    chk("rst_crstn", {63'd0, core_rstn}, 64'd0);
    chk("rst_en", {63'd0, core_en}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sc", {62'd0, stop_cause}, 64'd0);
    chk("rst_idx", {32'd0, probability_idx}, 64'd0);
    chk("rst_snap", snap_bits | snap_errors | probability_in, 64'd0);

    // table: start, RESET, LOAD of 0xA..0xD, SETTLE, first RUN cycle
    target_bits = 64'd1000;
    total_bit_errors_post = 64'd7;
    for (int i = 0; i < 10; i++) begin
      start = vecs[i].start; prob_valid = vecs[i].pv; prob_data = vecs[i].pdata;
      sb_q.push_back(vecs[i].e);
      tick();
      e = sb_q.pop_front();
      chk($sformatf("v%0d_ready", i), {63'd0, prob_ready}, {63'd0, e.ready});
      chk($sformatf("v%0d_crstn", i), {63'd0, core_rstn}, {63'd0, e.crstn});
      chk($sformatf("v%0d_en", i), {63'd0, core_en}, {63'd0, e.en});
      chk($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, e.busy});
      chk($sformatf("v%0d_done", i), {63'd0, done}, {63'd0, e.done});
      chk($sformatf("v%0d_sc", i), {62'd0, stop_cause}, {62'd0, e.sc});
      chk($sformatf("v%0d_pin", i), probability_in, e.pin);
      chk($sformatf("v%0d_idx", i), {32'd0, probability_idx}, {32'd0, e.idx});
    end
    start = 1'b0; prob_valid = 1'b0;

    // bit target: ramp 8/cycle, stop the cycle after total_bits reaches 1000
    drop_i = 0;
    for (int i = 1; i <= 200; i++) begin
      total_bits = 64'(8 * i);
      tick();
      if (!core_en) begin
        drop_i = i;
        break;
      end
    end
    chk("bits_stop_cycle", 64'(drop_i), 64'd125);
    chk("bits_sc", {62'd0, stop_cause}, 64'd1);
    // drain with moving totals and an ignored abort; snapshot takes the DONE-entry value
    for (int j = 1; j <= DRAIN; j++) begin
      total_bits = 64'(2000 + j);
      abort = (j == 2);
      tick();
      if (j == DRAIN - 1) chk("drain_not_done", {63'd0, done}, 64'd0);
    end
    abort = 1'b0;
    chk("done_after_drain", {63'd0, done}, 64'd1);
    chk("done_busy", {63'd0, busy}, 64'd0);
    chk("done_crstn", {63'd0, core_rstn}, 64'd1);
    chk("snap_bits", snap_bits, 64'd2005);
    chk("snap_errors", snap_errors, 64'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_in_done_sc", {62'd0, stop_cause}, 64'd1);
    chk("abort_in_done_done", {63'd0, done}, 64'd1);

    // toggling host valid: exactly N_PROB contiguous accepts, snapshot held meanwhile
    total_bits = 64'd0; total_bit_errors_post = 64'd0; target_bits = 64'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_sc_clear", {62'd0, stop_cause}, 64'd0);
    chk("snap_hold", snap_bits, 64'd2005);
    wait_ready(20);
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      prob_valid = (i % 2 == 0);
      prob_data = 64'(256 + acc);
      fire = prob_valid && prob_ready;
      tick();
      if (fire) begin
        chk($sformatf("tog_idx%0d", acc), {32'd0, probability_idx}, 64'(acc));
        chk($sformatf("tog_pin%0d", acc), probability_in, 64'(256 + acc));
        acc++;
        if (acc == N_PROB) begin
          chk("tog_ready_drop", {63'd0, prob_ready}, 64'd0);
          break;
        end
        chk("tog_crstn_low", {63'd0, core_rstn}, 64'd0);
      end
    end
    prob_valid = 1'b0;
    chk("tog_accepts", 64'(acc), 64'(N_PROB));
    total_bits = 64'd5;
    wait_done(50);
    chk("tog_sc", {62'd0, stop_cause}, 64'd1);

    // bits and errors cross together -> errors win; start while busy ignored
    total_bits = 64'd0; total_bit_errors_post = 64'd0;
    target_bits = 64'd100; target_errors = 64'd10;
    start_and_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy_en", {63'd0, core_en}, 64'd1);
    total_bits = 64'd50; total_bit_errors_post = 64'd5;
    tick();
    chk("below_target_en", {63'd0, core_en}, 64'd1);
    total_bits = 64'd100; total_bit_errors_post = 64'd10;
    tick();
    chk("both_en", {63'd0, core_en}, 64'd0);
    chk("both_sc", {62'd0, stop_cause}, 64'd2);
    wait_done(20);
    chk("both_snap_bits", snap_bits, 64'd100);
    chk("both_snap_errs", snap_errors, 64'd10);

    // abort together with both targets -> 11
    total_bits = 64'd0; total_bit_errors_post = 64'd0;
    start_and_run();
    total_bits = 64'd100; total_bit_errors_post = 64'd10; abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_all_en", {63'd0, core_en}, 64'd0);
    chk("abort_all_sc", {62'd0, stop_cause}, 64'd3);
    wait_done(20);

    // abort during LOAD after two words
    total_bits = 64'd0; total_bit_errors_post = 64'd0;
    target_bits = 64'd0; target_errors = 64'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready(20);
    prob_valid = 1'b1; prob_data = 64'h200;
    tick();
    prob_data = 64'h201;
    tick();
    prob_data = 64'h202; abort = 1'b1;
    tick();
    abort = 1'b0; prob_data = 64'h203;
    chk("ld_abort_ready", {63'd0, prob_ready}, 64'd0);
    chk("ld_abort_sc", {62'd0, stop_cause}, 64'd3);
    chk("ld_abort_busy", {63'd0, busy}, 64'd1);
    wait_done(20);
    prob_valid = 1'b0;
    chk("ld_abort_idx", {32'd0, probability_idx}, 64'd1);
    chk("ld_abort_pin", probability_in, 64'h201);

    // no targets: run only ends on watchdog (if built in) or abort
    total_bits = '1; total_bit_errors_post = '1;
    start_and_run();
`ifdef BER_RUN_TIMEOUT_EN
    en_cnt = 1;
    for (int k = 0; k < 300 && core_en; k++) begin
      tick();
      if (core_en) en_cnt++;
    end
    chk("timeout_en_cycles", 64'(en_cnt), 64'd100);
    chk("timeout_sc", {62'd0, stop_cause}, 64'd3);
`else
    en_cnt = 0;
    repeat (150) tick();
    chk("no_limit_en", {63'd0, core_en}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("no_limit_abort_sc", {62'd0, stop_cause}, 64'd3);
`endif
    wait_done(20);

    // rstn pulse mid-RUN: outputs return to reset values at once
    total_bits = 64'd0; total_bit_errors_post = 64'd0;
    start_and_run();
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_crstn", {63'd0, core_rstn}, 64'd0);
    chk("mid_rst_en", {63'd0, core_en}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_sc", {62'd0, stop_cause}, 64'd0);
    chk("mid_rst_idx", {32'd0, probability_idx}, 64'd0);
    chk("mid_rst_snap", snap_bits | snap_errors | probability_in, 64'd0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (4) tick();
    chk("post_rst_idle", {62'd0, busy, done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
